control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit directly upstream of the DataPath. Steps T0..T6 per instruction, decodes the IR word returned by the DataPath, and drives every bus-out, register-in, memory and ALU-select strobe that the DataPath consumes. Register selection is emitted as Gra/Grb/Grc plus Rin/Rout for the downstream select-and-encode logic; the sequencer never drives per-register strobes.

Parameters:
OPW, 5, opcode width (IR[31:27]); ALUop width
CNTW, 16, width of the retired-instruction counter

Ports:
Clock  in  1  system clock, rising edge active
Clear  in  1  asynchronous active-low reset
Start  in  1  leave IDLE or HALT; sampled on the rising edge
IR  in  32  DataPath instruction register; valid from T3
PCout, ZHighout, Zlowout, MDRout  out  1 each  bus drive enables
MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn  out  1 each  register load enables
IncPC, Read  out  1 each  PC increment; memory read
ALUop  out  OPW  ALU operation select
Gra, Grb, Grc  out  1 each  select IR Ra/Rb/Rc field
Rin, Rout  out  1 each  load/drive the selected GPR
Run  out  1  high while executing
InstrCount  out  CNTW  retired instructions, wraps at 2^CNTW
Illegal  out  1  see Optional Feature

Behaviour:
- Clear low (async): state=IDLE, InstrCount=0, all outputs 0.
- One state per clock. Strobes are a Moore function of the state register plus IR[31:27]; no glitching paths from Start.
- IDLE: all strobes 0, Run=0. Start=1 -> T0.
- T0: PCout, MARin, IncPC.
- T1: Read, MDRin.
- T2: MDRout, IRin. IR loads on the T2->T3 edge; decode happens in T3 only.
- Field map: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]. Example: 0x1A1B8000 = ADD R4,R3,R7.
- Three-register ALU class: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011.
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ALUop=opcode, ZLowIn.
  - T5: Zlowout, Gra, Rin.
  - Then T0. Six cycles total.
- MUL 01111 / DIV 10000:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, ALUop=opcode, ZLowIn, ZHighIn.
  - T5: Zlowout, LOin.
  - T6: ZHighout, HIin.
  - Then T0. Seven cycles total.
- NOP 11010: T3 drives no strobes, then T0.
- HALT 11011: T3 -> HALT. In HALT, Run=0 and all strobes 0; Start=1 -> T0.
- Any other opcode: treated as NOP (unless ILLEGAL_TRAP_EN is defined).
- ALUop=0 in every state except T4.
- Run=1 in T0..T6.
- InstrCount increments by 1 on the edge leaving the last execute state of any instruction, including NOP. HALT counts on entry to HALT. Wraps 0xFFFF->0.
- Start is ignored outside IDLE/HALT.
- Clear asserted mid-instruction: immediate IDLE with strobes 0. No partial writeback is completed.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an undefined opcode in T3 -> HALT with Illegal=1. Illegal stays 1 until Clear, or until Start leaves HALT, which clears it.
- Undefined: undefined opcodes behave as NOP, and Illegal is tied 0.

Test Plan:
- Reset: hold Clear=0 with Start=1 toggling -> all outputs 0, InstrCount=0; release, pulse Start -> T0 on the next edge with PCout=MARin=IncPC=1.
- ADD: IR=0x1A1B8000 -> check strobes cycle by cycle:
  - T1 Read&MDRin, T2 MDRout&IRin.
  - T3 Grb,Rout,Yin; T4 Grc,Rout,ZLowIn with ALUop=00011.
  - T5 Zlowout,Gra,Rin; back to T0 on cycle 6; InstrCount=1.
- MUL: IR=0x79180000 (opcode 01111) -> T4 ALUop=01111 with ZLowIn and ZHighIn; T5 LOin; T6 HIin; next instruction starts 7 cycles after the previous T0.
- HALT: IR=0xD8000000 -> HALT after T3, Run=0, outputs quiet for 10 cycles; Start=1 -> T0.
- Illegal opcode IR=0xF8000000:
  - Without macro: 4-cycle NOP, InstrCount+1.
  - With ILLEGAL_TRAP_EN: HALT and Illegal=1.
- Async reset in T4 of ADD -> ZLowIn and ALUop drop without waiting for a clock edge; Rin never asserted; force InstrCount=0xFFFF then retire one NOP -> 0x0000.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired T0..T6 control unit that drives the DataPath bus, register, memory and ALU strobes.
// Build option ILLEGAL_TRAP_EN: undefined opcodes trap into HALT and raise Illegal_o.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int CNTW = 16
) (
  input  logic            Clock_i,
  input  logic            Clear_i,
  input  logic            Start_i,
  input  logic [31:0]     IR_i,
  output logic            PCout_o,
  output logic            ZHighout_o,
  output logic            Zlowout_o,
  output logic            MDRout_o,
  output logic            MARin_o,
  output logic            PCin_o,
  output logic            MDRin_o,
  output logic            IRin_o,
  output logic            Yin_o,
  output logic            HIin_o,
  output logic            LOin_o,
  output logic            ZHighIn_o,
  output logic            ZLowIn_o,
  output logic            IncPC_o,
  output logic            Read_o,
  output logic [OPW-1:0]  ALUop_o,
  output logic            Gra_o,
  output logic            Grb_o,
  output logic            Grc_o,
  output logic            Rin_o,
  output logic            Rout_o,
  output logic            Run_o,
  output logic [CNTW-1:0] InstrCount_o,
  output logic            Illegal_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  state_e          state_q, state_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [OPW-1:0]  irOp;
  logic            unusedIrBits;

  assign irOp         = IR_i[31 -: OPW];
  assign unusedIrBits = ^IR_i[31-OPW:0];

  function automatic logic isAlu3(input logic [OPW-1:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  function automatic logic isMulDiv(input logic [OPW-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign Illegal_o = illegal_q;
`else
  assign Illegal_o = 1'b0;
`endif

  // The opcode is captured when leaving T3 so T4..T6 no longer depend on IR_i.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    count_d  = count_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      S_IDLE: if (Start_i) state_d = S_T0;
      S_HALT: begin
        if (Start_i) begin
          state_d = S_T0;
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b0;
`endif
        end
      end
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        opcode_d = irOp;
        if (isAlu3(irOp) || isMulDiv(irOp)) begin
          state_d = S_T4;
        end else if (irOp == OP_HALT) begin
          state_d = S_HALT;
          count_d = count_q + CNTW'(1);
        end else if (irOp == OP_NOP) begin
          state_d = S_T0;
          count_d = count_q + CNTW'(1);
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d   = S_HALT;
          illegal_d = 1'b1;
`else
          state_d = S_T0;
          count_d = count_q + CNTW'(1);
`endif
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (isMulDiv(opcode_q)) begin
          state_d = S_T6;
        end else begin
          state_d = S_T0;
          count_d = count_q + CNTW'(1);
        end
      end
      S_T6: begin
        state_d = S_T0;
        count_d = count_q + CNTW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock_i or negedge Clear_i) begin
    if (!Clear_i) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      count_q  <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign InstrCount_o = count_q;

  // T3 strobes need the IR word that only arrives on T3 entry, so strobes decode from the state register.
  always_comb begin
    PCout_o    = 1'b0;
    ZHighout_o = 1'b0;
    Zlowout_o  = 1'b0;
    MDRout_o   = 1'b0;
    MARin_o    = 1'b0;
    PCin_o     = 1'b0;
    MDRin_o    = 1'b0;
    IRin_o     = 1'b0;
    Yin_o      = 1'b0;
    HIin_o     = 1'b0;
    LOin_o     = 1'b0;
    ZHighIn_o  = 1'b0;
    ZLowIn_o   = 1'b0;
    IncPC_o    = 1'b0;
    Read_o     = 1'b0;
    ALUop_o    = '0;
    Gra_o      = 1'b0;
    Grb_o      = 1'b0;
    Grc_o      = 1'b0;
    Rin_o      = 1'b0;
    Rout_o     = 1'b0;
    Run_o      = 1'b0;
    unique case (state_q)
      S_T0: begin
        Run_o   = 1'b1;
        PCout_o = 1'b1;
        MARin_o = 1'b1;
        IncPC_o = 1'b1;
      end
      S_T1: begin
        Run_o   = 1'b1;
        Read_o  = 1'b1;
        MDRin_o = 1'b1;
      end
      S_T2: begin
        Run_o    = 1'b1;
        MDRout_o = 1'b1;
        IRin_o   = 1'b1;
      end
      S_T3: begin
        Run_o = 1'b1;
        if (isAlu3(irOp)) begin
          Grb_o  = 1'b1;
          Rout_o = 1'b1;
          Yin_o  = 1'b1;
        end else if (isMulDiv(irOp)) begin
          Gra_o  = 1'b1;
          Rout_o = 1'b1;
          Yin_o  = 1'b1;
        end
      end
      S_T4: begin
        Run_o    = 1'b1;
        Rout_o   = 1'b1;
        ALUop_o  = opcode_q;
        ZLowIn_o = 1'b1;
        if (isMulDiv(opcode_q)) begin
          Grb_o     = 1'b1;
          ZHighIn_o = 1'b1;
        end else begin
          Grc_o = 1'b1;
        end
      end
      S_T5: begin
        Run_o     = 1'b1;
        Zlowout_o = 1'b1;
        if (isMulDiv(opcode_q)) begin
          LOin_o = 1'b1;
        end else begin
          Gra_o = 1'b1;
          Rin_o = 1'b1;
        end
      end
      S_T6: begin
        Run_o      = 1'b1;
        ZHighout_o = 1'b1;
        HIin_o     = 1'b1;
      end
      default: begin
        Run_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer: a per-opcode strobe table model drives the expectations.
// A second instance with a 3-bit counter shares all inputs so counter wrap is seen within a short run.
module tb_control_sequencer;

  localparam int OPW   = 5;
  localparam int CNTW  = 16;
  localparam int SCNTW = 3;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Strobe vector layout: {Run, PCout, ZHighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin,
  //                        HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALUop[4:0]}
  typedef logic [25:0] vec_t;
  typedef vec_t vecq_t[$];

  localparam vec_t B_RUN   = vec_t'(1) << 25;
  localparam vec_t B_PCOUT = vec_t'(1) << 24;
  localparam vec_t B_ZHOUT = vec_t'(1) << 23;
  localparam vec_t B_ZLOUT = vec_t'(1) << 22;
  localparam vec_t B_MDROUT= vec_t'(1) << 21;
  localparam vec_t B_MARIN = vec_t'(1) << 20;
  localparam vec_t B_MDRIN = vec_t'(1) << 18;
  localparam vec_t B_IRIN  = vec_t'(1) << 17;
  localparam vec_t B_YIN   = vec_t'(1) << 16;
  localparam vec_t B_HIIN  = vec_t'(1) << 15;
  localparam vec_t B_LOIN  = vec_t'(1) << 14;
  localparam vec_t B_ZHIN  = vec_t'(1) << 13;
  localparam vec_t B_ZLIN  = vec_t'(1) << 12;
  localparam vec_t B_INCPC = vec_t'(1) << 11;
  localparam vec_t B_READ  = vec_t'(1) << 10;
  localparam vec_t B_GRA   = vec_t'(1) << 9;
  localparam vec_t B_GRB   = vec_t'(1) << 8;
  localparam vec_t B_GRC   = vec_t'(1) << 7;
  localparam vec_t B_RIN   = vec_t'(1) << 6;
  localparam vec_t B_ROUT  = vec_t'(1) << 5;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] ir;

  wire [25:0]       obsA;
  wire [25:0]       obsS;
  wire [CNTW-1:0]  cntA;
  wire [SCNTW-1:0] cntS;
  wire             illA;
  wire             illS;

  int          checks;
  int          passes;
  int unsigned modelCount;
  bit          modelIllegal;

  always #5 clock = ~clock;

  control_sequencer #(.OPW(OPW), .CNTW(CNTW)) dut (
    .Clock_i(clock), .Clear_i(clear), .Start_i(start), .IR_i(ir),
    .PCout_o(obsA[24]), .ZHighout_o(obsA[23]), .Zlowout_o(obsA[22]), .MDRout_o(obsA[21]),
    .MARin_o(obsA[20]), .PCin_o(obsA[19]), .MDRin_o(obsA[18]), .IRin_o(obsA[17]),
    .Yin_o(obsA[16]), .HIin_o(obsA[15]), .LOin_o(obsA[14]), .ZHighIn_o(obsA[13]),
    .ZLowIn_o(obsA[12]), .IncPC_o(obsA[11]), .Read_o(obsA[10]), .ALUop_o(obsA[4:0]),
    .Gra_o(obsA[9]), .Grb_o(obsA[8]), .Grc_o(obsA[7]), .Rin_o(obsA[6]), .Rout_o(obsA[5]),
    .Run_o(obsA[25]), .InstrCount_o(cntA), .Illegal_o(illA)
  );

  control_sequencer #(.OPW(OPW), .CNTW(SCNTW)) dutSmall (
    .Clock_i(clock), .Clear_i(clear), .Start_i(start), .IR_i(ir),
    .PCout_o(obsS[24]), .ZHighout_o(obsS[23]), .Zlowout_o(obsS[22]), .MDRout_o(obsS[21]),
    .MARin_o(obsS[20]), .PCin_o(obsS[19]), .MDRin_o(obsS[18]), .IRin_o(obsS[17]),
    .Yin_o(obsS[16]), .HIin_o(obsS[15]), .LOin_o(obsS[14]), .ZHighIn_o(obsS[13]),
    .ZLowIn_o(obsS[12]), .IncPC_o(obsS[11]), .Read_o(obsS[10]), .ALUop_o(obsS[4:0]),
    .Gra_o(obsS[9]), .Grb_o(obsS[8]), .Grc_o(obsS[7]), .Rin_o(obsS[6]), .Rout_o(obsS[5]),
    .Run_o(obsS[25]), .InstrCount_o(cntS), .Illegal_o(illS)
  );

  function automatic bit isAluOp(input logic [4:0] op);
    return (op >= 5'd3) && (op <= 5'd11);
  endfunction

  function automatic bit isMulDivOp(input logic [4:0] op);
    return (op == 5'd15) || (op == 5'd16);
  endfunction

  function automatic bit isUndefOp(input logic [4:0] op);
    return !isAluOp(op) && !isMulDivOp(op) && (op != 5'd26) && (op != 5'd27);
  endfunction

  // Expected per-cycle strobes for one instruction, straight from the instruction-class table.
  function automatic vecq_t buildSeq(input logic [4:0] op);
    vecq_t s;
    s.push_back(B_RUN | B_PCOUT | B_MARIN | B_INCPC);
    s.push_back(B_RUN | B_READ | B_MDRIN);
    s.push_back(B_RUN | B_MDROUT | B_IRIN);
    if (isAluOp(op)) begin
      s.push_back(B_RUN | B_GRB | B_ROUT | B_YIN);
      s.push_back(B_RUN | B_GRC | B_ROUT | B_ZLIN | vec_t'(op));
      s.push_back(B_RUN | B_ZLOUT | B_GRA | B_RIN);
    end else if (isMulDivOp(op)) begin
      s.push_back(B_RUN | B_GRA | B_ROUT | B_YIN);
      s.push_back(B_RUN | B_GRB | B_ROUT | B_ZLIN | B_ZHIN | vec_t'(op));
      s.push_back(B_RUN | B_ZLOUT | B_LOIN);
      s.push_back(B_RUN | B_ZHOUT | B_HIIN);
    end else begin
      s.push_back(B_RUN);
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t exp);
    logic [31:0] mc;
    mc = modelCount;
    checkOutput(tag, {illA, obsA}, {modelIllegal, exp});
    checkOutput({tag, ".cnt"}, cntA, mc[15:0]);
    checkOutput({tag, ".small"}, {illS, cntS, obsS}, {modelIllegal, mc[2:0], exp});
  endtask

  // Runs one instruction from T0; the caller has arranged that the next rising edge enters T0.
  task automatic applyStimulus(input logic [31:0] word, input int abortAt, input int haltCycles);
    logic [4:0]  op;
    vecq_t       seq;
    bit          halts;
    bit          trap;
    int          nHalt;
    logic [31:0] rnd;
    op    = word[31:27];
    seq   = buildSeq(op);
    trap  = TRAP_EN && isUndefOp(op);
    halts = (op == 5'd27) || trap;
    for (int k = 0; k < seq.size(); k++) begin
      @(negedge clock);
      checkAll($sformatf("op%0d.T%0d", op, k), seq[k]);
      if (k == abortAt) return;
      rnd = $urandom();
      if (k < 2) ir = rnd;
      else if (k == 2) ir = word;
      start = (halts && k == seq.size() - 1) ? 1'b0 : rnd[27];
    end
    if (!trap) modelCount++;
    if (halts) begin
      modelIllegal = trap;
      nHalt = (haltCycles > 0) ? haltCycles : int'($urandom_range(1, 4));
      for (int h = 0; h < nHalt; h++) begin
        @(negedge clock);
        checkAll($sformatf("halt%0d", h), '0);
        start = (h == nHalt - 1);
      end
      modelIllegal = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rnd;
    logic [4:0]  op;
    int          r;
    checks       = 0;
    passes       = 0;
    modelCount   = 0;
    modelIllegal = 1'b0;
    clear = 1'b1;
    start = 1'b0;
    ir    = '0;
    #2 clear = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkAll("reset", '0);
      start = ~start;
    end
    clear = 1'b1;
    start = 1'b0;
    @(negedge clock);
    checkAll("idle", '0);
    start = 1'b1;

    applyStimulus(32'h1A1B8000, -1, 0);
    applyStimulus(32'h79180000, -1, 0);
    applyStimulus(32'hF8000000, -1, 0);
    applyStimulus(32'hD0000000, -1, 0);
    applyStimulus(32'hD8000000, -1, 10);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      op = 5'($urandom_range(3, 11));
      else if (r < 62) op = ($urandom_range(0, 1) != 0) ? 5'd15 : 5'd16;
      else if (r < 74) op = 5'd26;
      else if (r < 82) op = 5'd27;
      else begin
        op = 5'd0;
        for (int t = 0; t < 32; t++) begin
          op = 5'($urandom_range(0, 31));
          if (isUndefOp(op)) break;
        end
        if (!isUndefOp(op)) op = 5'd31;
      end
      rnd = $urandom();
      applyStimulus({op, rnd[26:0]}, -1, 0);
    end

    applyStimulus(32'h1A1B8000, 4, 0);
    #2 clear = 1'b0;
    #1 modelCount = 0;
    modelIllegal = 1'b0;
    checkAll("asyncClear", '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkAll("heldClear", '0);
    end
    clear = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(32'hD0000000, -1, 0);
    end
    @(negedge clock);
    checkAll("afterWrap", B_RUN | B_PCOUT | B_MARIN | B_INCPC);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
